// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with the IF/ID pipeline register folded in.
// Owns the PC, talks to a variable-latency instruction memory over a
// req/ack handshake, honours the hazard unit's freeze and the EX-stage
// branch redirect, and presents {PC+4, instruction, valid} to decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | request outstanding for pc; ack delivers, parks or is dropped
// HOLD  | ack arrived under freeze; instruction parked in skid buffer
// DRAIN | redirect seen mid-request; wait out the old ack, then go to target
module if_stage_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       BUBBLE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [31:0]       instr_out,
    output logic              valid_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetchStateT;

    fetchStateT        state;
    fetchStateT        stateNext;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcNext;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] targetNext;
    logic [31:0]       skidBuf;
    logic [31:0]       skidBufNext;

    logic [ADDR_W-1:0] pcPlus4;
    logic              deliver;
    logic [31:0]       deliverInstr;

    logic [ADDR_W-1:0] pcOutNext;
    logic [31:0]       instrOutNext;
    logic              validOutNext;

    // Wraps naturally modulo 2^ADDR_W.
    assign pcPlus4 = pc + ADDR_W'(4);

    // State register together with the PC, redirect target, skid buffer and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            target    <= '0;
            skidBuf   <= '0;
            pc_out    <= '0;
            instr_out <= BUBBLE;
            valid_out <= 1'b0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            target    <= targetNext;
            skidBuf   <= skidBufNext;
            pc_out    <= pcOutNext;
            instr_out <= instrOutNext;
            valid_out <= validOutNext;
        end
    end

    // Next-state and fetch datapath; redirect beats freeze beats normal flow.
    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        targetNext   = target;
        skidBufNext  = skidBuf;
        deliver      = 1'b0;
        deliverInstr = skidBuf;

        unique case (state)
            FETCH: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        // Fetched word belongs to the wrong path.
                        pcNext = branch_addr;
                    end else if (freeze) begin
                        // Park the word so the stall does not lose it.
                        skidBufNext = imem_rdata;
                        stateNext   = HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliverInstr = imem_rdata;
                        pcNext       = pcPlus4;
                    end
                end else if (branch_taken) begin
                    // The memory cannot abort, so remember where to go once it answers.
                    targetNext = branch_addr;
                    stateNext  = DRAIN;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    skidBufNext = '0;
                    pcNext      = branch_addr;
                    stateNext   = FETCH;
                end else if (!freeze) begin
                    deliver      = 1'b1;
                    deliverInstr = skidBuf;
                    pcNext       = pcPlus4;
                    stateNext    = FETCH;
                end
            end

            DRAIN: begin
                // Later redirects override earlier ones; freeze has no effect here.
                if (branch_taken) begin
                    targetNext = branch_addr;
                end
                if (imem_ack) begin
                    pcNext    = branch_taken ? branch_addr : target;
                    stateNext = FETCH;
                end
            end

            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    // IF/ID register update: flush, hold, load a delivered word, or insert a bubble.
    always_comb begin
        pcOutNext    = pc_out;
        instrOutNext = instr_out;
        validOutNext = valid_out;

        if (branch_taken) begin
            pcOutNext    = '0;
            instrOutNext = BUBBLE;
            validOutNext = 1'b0;
        end else if (freeze) begin
            pcOutNext    = pc_out;
            instrOutNext = instr_out;
            validOutNext = valid_out;
        end else if (deliver) begin
            pcOutNext    = pcPlus4;
            instrOutNext = deliverInstr;
            validOutNext = 1'b1;
        end else begin
            // Never re-present a stale instruction to decode.
            pcOutNext    = '0;
            instrOutNext = BUBBLE;
            validOutNext = 1'b0;
        end
    end

    // Memory-side outputs: request in every state except HOLD, address is always the PC.
    always_comb begin
        imem_req  = (state != HOLD);
        imem_addr = pc;
    end

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with a small instruction-memory model
// whose data is 0x1000 + address and whose ack latency is adjustable.
module tb_if_stage_fetch;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemAck;
    logic [31:0] pcOut;
    logic [31:0] instrOut;
    logic        validOut;

    int memLat;
    int waitCnt;
    int checks;
    int errors;

    if_stage_fetch #(
        .ADDR_W  (32),
        .RESET_PC(32'h0000_0000),
        .BUBBLE  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branchTaken),
        .branch_addr (branchAddr),
        .imem_req    (imemReq),
        .imem_addr   (imemAddr),
        .imem_rdata  (imemRdata),
        .imem_ack    (imemAck),
        .pc_out      (pcOut),
        .instr_out   (instrOut),
        .valid_out   (validOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack once the request has been held for memLat cycles.
    assign imemRdata = 32'h0000_1000 + imemAddr;
    assign imemAck   = imemReq && (waitCnt == memLat);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= 0;
        end else if (imemReq && imemAck) begin
            waitCnt <= 0;
        end else if (imemReq) begin
            waitCnt <= waitCnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOut(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
        check({tag, ".valid"}, {31'd0, validOut}, {31'd0, v});
        check({tag, ".pc"}, pcOut, p);
        check({tag, ".instr"}, instrOut, i);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        memLat      = 0;
        rst         = 1'b1;
        freeze      = 1'b0;
        branchTaken = 1'b0;
        branchAddr  = 32'h0;

        // Reset state
        tick();
        checkOut("rst", 1'b0, 32'h0, 32'h0);
        check("rst.req", {31'd0, imemReq}, 32'd1);
        check("rst.addr", imemAddr, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("c0.addr", imemAddr, 32'h0);
        check("c0.req", {31'd0, imemReq}, 32'd1);

        // Zero-wait streaming
        tick();
        checkOut("e1", 1'b1, 32'h4, 32'h1000);
        check("e1.addr", imemAddr, 32'h4);
        tick();
        checkOut("e2", 1'b1, 32'h8, 32'h1004);
        check("e2.addr", imemAddr, 32'h8);

        // Freeze coincident with ack of 8 for three cycles
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz.req", {31'd0, imemReq}, 32'd0);
            checkOut("frz", 1'b1, 32'h8, 32'h1004);
        end
        freeze = 1'b0;
        tick();
        checkOut("rel", 1'b1, 32'hC, 32'h1008);
        check("rel.req", {31'd0, imemReq}, 32'd1);
        check("rel.addr", imemAddr, 32'hC);
        tick();
        checkOut("e7", 1'b1, 32'h10, 32'h100C);

        // Park instr@16, then branch to 0x40 under freeze
        freeze = 1'b1;
        tick();
        checkOut("park", 1'b1, 32'h10, 32'h100C);
        branchTaken = 1'b1;
        branchAddr  = 32'h40;
        tick();
        checkOut("brfrz", 1'b0, 32'h0, 32'h0);
        check("brfrz.addr", imemAddr, 32'h40);
        check("brfrz.req", {31'd0, imemReq}, 32'd1);
        branchTaken = 1'b0;
        freeze      = 1'b0;
        tick();
        checkOut("e10", 1'b1, 32'h44, 32'h1040);

        // Redirect to 0x10, then 3-cycle memory with branch to 0x80 mid-request
        branchTaken = 1'b1;
        branchAddr  = 32'h10;
        tick();
        branchTaken = 1'b0;
        memLat      = 3;
        check("l3.addr0", imemAddr, 32'h10);
        tick();
        check("l3.v1", {31'd0, validOut}, 32'd0);
        branchTaken = 1'b1;
        branchAddr  = 32'h80;
        tick();
        branchTaken = 1'b0;
        check("l3.addr1", imemAddr, 32'h10);
        check("l3.v2", {31'd0, validOut}, 32'd0);
        tick();
        check("l3.addr2", imemAddr, 32'h10);
        check("l3.ack", {31'd0, imemAck}, 32'd1);
        check("l3.v3", {31'd0, validOut}, 32'd0);
        tick();
        check("l3.addr3", imemAddr, 32'h80);
        check("l3.v4", {31'd0, validOut}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("l3.wait", {31'd0, validOut}, 32'd0);
            check("l3.waddr", imemAddr, 32'h80);
        end
        tick();
        checkOut("l3.dlv", 1'b1, 32'h84, 32'h1080);

        // Two redirects while draining: latest wins
        branchTaken = 1'b1;
        branchAddr  = 32'h80;
        tick();
        branchAddr  = 32'hC0;
        tick();
        branchTaken = 1'b0;
        check("dr.addr", imemAddr, 32'h84);
        tick();
        check("dr.ack", {31'd0, imemAck}, 32'd1);
        tick();
        check("dr.next", imemAddr, 32'hC0);
        check("dr.v", {31'd0, validOut}, 32'd0);
        repeat (3) tick();
        tick();
        checkOut("dr.dlv", 1'b1, 32'hC4, 32'h10C0);

        // Async reset mid-wait, then wrap near top of address space
        tick();
        rst = 1'b1;
        #1;
        checkOut("arst", 1'b0, 32'h0, 32'h0);
        check("arst.addr", imemAddr, 32'h0);
        memLat = 0;
        #1;
        rst = 1'b0;
        #1;
        check("arst.rel", imemAddr, 32'h0);
        branchTaken = 1'b1;
        branchAddr  = 32'hFFFF_FFF8;
        tick();
        branchTaken = 1'b0;
        check("wr.addr0", imemAddr, 32'hFFFF_FFF8);
        tick();
        checkOut("wr1", 1'b1, 32'hFFFF_FFFC, 32'h0000_0FF8);
        check("wr.addr1", imemAddr, 32'hFFFF_FFFC);
        tick();
        checkOut("wr2", 1'b1, 32'h0, 32'h0000_0FFC);
        check("wr.addr2", imemAddr, 32'h0);
        tick();
        checkOut("wr3", 1'b1, 32'h4, 32'h0000_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
